multicycle_controller: RTL and testbench

// Multi-cycle main control FSM for the RV32I datapath; successor of the single-cycle opcode decoder.

---
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM for the RV32I datapath: sequences FETCH/DECODE/EXEC/MEM/WB
// over a shared instruction/data memory, with a ready handshake, memory timeout and retire counter.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit ENABLE_LUI  = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // Counter only has to reach MEM_TIMEOUT-1; the compare is masked off when MEM_TIMEOUT is 0.
  localparam int              WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [6:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  instret_q;
  logic              illegal_q;
  logic              timeout_q;
  logic              dec_ok;
  logic              mem_wait;
  logic              wait_expired;

  assign mem_wait     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign wait_expired = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == WAIT_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dec_ok = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL: dec_ok = 1'b1;
      OP_LUI:                                  dec_ok = ENABLE_LUI;
      default:                                 dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_DECODE: state_d = dec_ok ? S_EXEC : S_FAULT;
      S_EXEC: begin
        case (op_q)
          OP_R, OP_I, OP_LUI: state_d = S_WB;
          OP_LW, OP_SW:       state_d = S_MEM;
          OP_BR, OP_JAL:      state_d = S_FETCH;
          default:            state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (mem_ready)         state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        if (!dec_ok) illegal_q <= 1'b1;
      end
      // Any cycle that is not a stalled memory wait restarts the count, including entry to FETCH/MEM.
      wait_cnt <= mem_wait ? wait_cnt + WAIT_W'(1) : '0;
      if (wait_expired) timeout_q <= 1'b1;
      if (instr_done)   instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Control outputs: Moore on state/op_q, except FETCH load strobes and the SW retire on mem_ready.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_EXEC: begin
          case (op_q)
            OP_R: begin
              alu_src_a = 2'b10;
              alu_op    = 2'b10;
            end
            OP_I: begin
              alu_src_a = 2'b10;
              alu_src_b = 2'b10;
              alu_op    = 2'b10;
            end
            OP_LW, OP_SW: begin
              alu_src_a = 2'b10;
              alu_src_b = 2'b10;
            end
            OP_BR: begin
              alu_src_a  = 2'b10;
              alu_op     = 2'b01;
              branch     = 1'b1;
              instr_done = 1'b1;
            end
            OP_JAL: begin
              pc_write   = 1'b1;
              reg_write  = 1'b1;
              result_src = 2'b10;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req    = 1'b1;
          i_or_d     = 1'b1;
          mem_we     = (op_q == OP_SW);
          instr_done = (op_q == OP_SW) && mem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          if (op_q == OP_LW)       result_src = 2'b01;
          else if (op_q == OP_LUI) result_src = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign instret = reset ? '0 : instret_q;
  assign illegal = !reset && illegal_q;
  assign timeout = !reset && timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a default instance plus a LUI-disabled, 4-bit-counter
// instance sharing the same stimulus.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;

  logic        mem_req1, mem_we1, i_or_d1, ir_write1, pc_write1, branch1, reg_write1, instr_done1;
  logic [1:0]  alu_src_a1, alu_src_b1, alu_op1, result_src1;
  logic        illegal1, timeout1;
  logic [2:0]  state1;
  logic [31:0] instret1;

  logic        mem_req2, mem_we2, i_or_d2, ir_write2, pc_write2, branch2, reg_write2, instr_done2;
  logic [1:0]  alu_src_a2, alu_src_b2, alu_op2, result_src2;
  logic        illegal2, timeout2;
  logic [2:0]  state2;
  logic [3:0]  instret2;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Control word: mem_req mem_we i_or_d ir_write pc_write branch src_a src_b alu_op result_src reg_write instr_done
  localparam logic [15:0] C_NONE     = 16'h0000;
  localparam logic [15:0] C_FETCH_W  = 16'h8040;
  localparam logic [15:0] C_FETCH_R  = 16'h9840;
  localparam logic [15:0] C_DECODE   = 16'h0180;
  localparam logic [15:0] C_EXEC_R   = 16'h0220;
  localparam logic [15:0] C_EXEC_I   = 16'h02A0;
  localparam logic [15:0] C_EXEC_ADR = 16'h0280;
  localparam logic [15:0] C_EXEC_BR  = 16'h0611;
  localparam logic [15:0] C_EXEC_JAL = 16'h080B;
  localparam logic [15:0] C_MEM_LW   = 16'hA000;
  localparam logic [15:0] C_MEM_SW_W = 16'hE000;
  localparam logic [15:0] C_MEM_SW_R = 16'hE001;
  localparam logic [15:0] C_WB_ALU   = 16'h0003;
  localparam logic [15:0] C_WB_LW    = 16'h0007;
  localparam logic [15:0] C_WB_LUI   = 16'h000F;

  wire [15:0] ctl1 = {mem_req1, mem_we1, i_or_d1, ir_write1, pc_write1, branch1, alu_src_a1,
                      alu_src_b1, alu_op1, result_src1, reg_write1, instr_done1};
  wire [15:0] ctl2 = {mem_req2, mem_we2, i_or_d2, ir_write2, pc_write2, branch2, alu_src_a2,
                      alu_src_b2, alu_op2, result_src2, reg_write2, instr_done2};

  multicycle_controller dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req1), .mem_we(mem_we1), .i_or_d(i_or_d1), .ir_write(ir_write1),
    .pc_write(pc_write1), .branch(branch1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
    .alu_op(alu_op1), .result_src(result_src1), .reg_write(reg_write1), .instr_done(instr_done1),
    .illegal(illegal1), .timeout(timeout1), .state(state1), .instret(instret1)
  );

  multicycle_controller #(.MEM_TIMEOUT(16), .ENABLE_LUI(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_we(mem_we2), .i_or_d(i_or_d2), .ir_write(ir_write2),
    .pc_write(pc_write2), .branch(branch2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .alu_op(alu_op2), .result_src(result_src2), .reg_write(reg_write2), .instr_done(instr_done2),
    .illegal(illegal2), .timeout(timeout2), .state(state2), .instret(instret2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the current cycle of dut1 (inputs already applied), then advances one clock.
  task automatic at_cycle(input string tag, input logic [2:0] st, input logic [15:0] c);
    #1;
    check({tag, ".state"}, 32'(state1), 32'(st));
    check({tag, ".ctl"}, 32'(ctl1), 32'(c));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    tick();
    tick();
    #1;
    check("rst.state", 32'(state1), 32'd0);
    check("rst.ctl", 32'(ctl1), 32'(C_NONE));
    check("rst.instret", instret1, 32'd0);
    check("rst.flags", {30'd0, illegal1, timeout1}, 32'd0);
    reset = 1'b0;

    // R-type, memory always ready
    opcode    = OP_R;
    mem_ready = 1'b1;
    at_cycle("r.fetch", 3'd0, C_FETCH_R);
    at_cycle("r.decode", 3'd1, C_DECODE);
    at_cycle("r.exec", 3'd2, C_EXEC_R);
    at_cycle("r.wb", 3'd4, C_WB_ALU);
    check("r.instret", instret1, 32'd1);

    opcode = OP_I;
    at_cycle("i.fetch", 3'd0, C_FETCH_R);
    at_cycle("i.decode", 3'd1, C_DECODE);
    at_cycle("i.exec", 3'd2, C_EXEC_I);
    at_cycle("i.wb", 3'd4, C_WB_ALU);
    check("i.instret", instret1, 32'd2);

    // LW with three stalled MEM cycles: 8 cycles total
    opcode = OP_LW;
    at_cycle("lw.fetch", 3'd0, C_FETCH_R);
    at_cycle("lw.decode", 3'd1, C_DECODE);
    at_cycle("lw.exec", 3'd2, C_EXEC_ADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) at_cycle("lw.mem_wait", 3'd3, C_MEM_LW);
    mem_ready = 1'b1;
    at_cycle("lw.mem_rdy", 3'd3, C_MEM_LW);
    at_cycle("lw.wb", 3'd4, C_WB_LW);
    check("lw.instret", instret1, 32'd3);

    opcode = OP_SW;
    at_cycle("sw.fetch", 3'd0, C_FETCH_R);
    at_cycle("sw.decode", 3'd1, C_DECODE);
    at_cycle("sw.exec", 3'd2, C_EXEC_ADR);
    mem_ready = 1'b0;
    at_cycle("sw.mem_wait", 3'd3, C_MEM_SW_W);
    mem_ready = 1'b1;
    at_cycle("sw.mem_rdy", 3'd3, C_MEM_SW_R);
    check("sw.instret", instret1, 32'd4);
    check("sw.back_fetch", 32'(state1), 32'd0);

    opcode = OP_BR;
    at_cycle("br.fetch", 3'd0, C_FETCH_R);
    at_cycle("br.decode", 3'd1, C_DECODE);
    at_cycle("br.exec", 3'd2, C_EXEC_BR);
    check("br.instret", instret1, 32'd5);

    opcode = OP_JAL;
    at_cycle("jal.fetch", 3'd0, C_FETCH_R);
    at_cycle("jal.decode", 3'd1, C_DECODE);
    at_cycle("jal.exec", 3'd2, C_EXEC_JAL);
    check("jal.instret", instret1, 32'd6);

    // LUI: legal on dut1, illegal on the LUI-disabled instance
    opcode = OP_LUI;
    at_cycle("lui.fetch", 3'd0, C_FETCH_R);
    at_cycle("lui.decode", 3'd1, C_DECODE);
    at_cycle("lui.exec", 3'd2, C_NONE);
    check("lui_off.state", 32'(state2), 32'd7);
    check("lui_off.illegal", 32'(illegal2), 32'd1);
    check("lui_off.ctl", 32'(ctl2), 32'(C_NONE));
    at_cycle("lui.wb", 3'd4, C_WB_LUI);
    check("lui.instret", instret1, 32'd7);
    check("lui.illegal", 32'(illegal1), 32'd0);

    // Unsupported opcode: FAULT held 20 cycles regardless of mem_ready
    do_reset();
    opcode = OP_BAD;
    at_cycle("bad.fetch", 3'd0, C_FETCH_R);
    at_cycle("bad.decode", 3'd1, C_DECODE);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      at_cycle("bad.fault", 3'd7, C_NONE);
    end
    check("bad.illegal", 32'(illegal1), 32'd1);
    check("bad.timeout", 32'(timeout1), 32'd0);
    check("bad.instret", instret1, 32'd0);

    // FETCH timeout after 16 unanswered cycles
    do_reset();
    opcode    = OP_R;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) at_cycle("to.fetch", 3'd0, C_FETCH_W);
    check("to.state", 32'(state1), 32'd7);
    check("to.timeout", 32'(timeout1), 32'd1);
    check("to.illegal", 32'(illegal1), 32'd0);
    mem_ready = 1'b1;
    at_cycle("to.hold", 3'd7, C_NONE);
    check("to.hold2", 32'(state1), 32'd7);

    // mem_ready on the 16th FETCH cycle wins; then LW times out in MEM
    do_reset();
    opcode    = OP_LW;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) at_cycle("to16.fetch", 3'd0, C_FETCH_W);
    mem_ready = 1'b1;
    at_cycle("to16.fetch_rdy", 3'd0, C_FETCH_R);
    check("to16.timeout", 32'(timeout1), 32'd0);
    at_cycle("to16.decode", 3'd1, C_DECODE);
    at_cycle("to16.exec", 3'd2, C_EXEC_ADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) at_cycle("tomem.wait", 3'd3, C_MEM_LW);
    check("tomem.state", 32'(state1), 32'd7);
    check("tomem.timeout", 32'(timeout1), 32'd1);

    // Reset asserted mid-instruction in MEM
    do_reset();
    opcode    = OP_BR;
    mem_ready = 1'b1;
    at_cycle("rm.br_fetch", 3'd0, C_FETCH_R);
    at_cycle("rm.br_decode", 3'd1, C_DECODE);
    at_cycle("rm.br_exec", 3'd2, C_EXEC_BR);
    check("rm.instret_pre", instret1, 32'd1);
    opcode = OP_SW;
    at_cycle("rm.sw_fetch", 3'd0, C_FETCH_R);
    at_cycle("rm.sw_decode", 3'd1, C_DECODE);
    at_cycle("rm.sw_exec", 3'd2, C_EXEC_ADR);
    mem_ready = 1'b0;
    at_cycle("rm.sw_mem", 3'd3, C_MEM_SW_W);
    reset = 1'b1;
    #1;
    check("rm.in_reset_state", 32'(state1), 32'd3);
    check("rm.in_reset_ctl", 32'(ctl1), 32'(C_NONE));
    tick();
    reset = 1'b0;
    #1;
    check("rm.after_state", 32'(state1), 32'd0);
    check("rm.after_instret", instret1, 32'd0);

    // 16 branches: 4-bit counter wraps to 0, 32-bit one reaches 16
    opcode    = OP_BR;
    mem_ready = 1'b1;
    repeat (45) tick();
    check("wrap.cnt4_15", 32'(instret2), 32'd15);
    check("wrap.cnt32_15", instret1, 32'd15);
    repeat (3) tick();
    check("wrap.cnt4_0", 32'(instret2), 32'd0);
    check("wrap.cnt32_16", instret1, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
